// File: rtl/iterative_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, register indices.
// No logic; constants and types only.
// Not applicable (no handshake in a package).
package iterative_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_UDIV  = 2'b01,
        OP_SDIV  = 2'b10,
        OP_UMULH = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_e;

    // Register 31 reads as zero in the register file; writes to it are dropped there.
    localparam int XZR_IDX = 31;

    // Iteration counter must hold 0..width-1 with headroom for the terminal compare.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/muldiv_signmag.sv
// Two's-complement conditional negate: yields |x| on entry and the signed quotient on exit.
// Purely combinational, zero cycles.
// No flow control; output follows input.
module muldiv_signmag #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] val_o
);

    // Negate when requested; the most-negative value maps to itself, which is what the
    // SDIV overflow case (MIN / -1) relies on.
    always_comb begin
        val_o = neg_i ? ('0 - val_i) : val_i;
    end

endmodule

// File: rtl/iterative_muldiv.sv
// Iterative MUL/UDIV/SDIV (and optional UMULH under MULDIV_UMULH_EN), one bit per clock.
// Fixed latency: Done rises WIDTH+1 edges after the accepting edge, for every op and operand.
// No queuing: Start is only honoured in IDLE (which includes the Done cycle); otherwise dropped.
module iterative_muldiv
    import iterative_muldiv_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int RADDR_W = 5
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [1:0]         Op,
    input  logic [WIDTH-1:0]   BusA,
    input  logic [WIDTH-1:0]   BusB,
    input  logic [RADDR_W-1:0] RW,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   Result,
    output logic [RADDR_W-1:0] RWOut,
    output logic               RegWrOut
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    op_e                  op_q, op_d;
    // MUL: hi = upper product half, lo = multiplier shifting out / lower half shifting in.
    // DIV: hi = partial remainder, lo = dividend shifting out / quotient shifting in.
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic                 neg_q, neg_d;     // SDIV quotient needs negation
    logic                 div0_q, div0_d;   // divisor was zero at accept
    logic [RADDR_W-1:0]   dst_q, dst_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [RADDR_W-1:0]   rwout_q, rwout_d;
    logic                 done_q, done_d;

    logic                 in_sdiv;
    logic                 in_div;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     quot_signed;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_diff;
    logic                 rem_ge;

    assign in_sdiv = (Op == OP_SDIV);
    assign in_div  = (Op == OP_UDIV) || (Op == OP_SDIV);

    muldiv_signmag #(.WIDTH(WIDTH)) u_abs_a (
        .val_i (BusA),
        .neg_i (in_sdiv && BusA[WIDTH-1]),
        .val_o (a_mag)
    );

    muldiv_signmag #(.WIDTH(WIDTH)) u_abs_b (
        .val_i (BusB),
        .neg_i (in_sdiv && BusB[WIDTH-1]),
        .val_o (b_mag)
    );

    muldiv_signmag #(.WIDTH(WIDTH)) u_fix_q (
        .val_i (lo_q),
        .neg_i (neg_q),
        .val_o (quot_signed)
    );

    // One iteration of each datapath; the FSM picks which result to keep.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
        rem_sh   = {hi_q, lo_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        rem_ge   = ~rem_diff[WIDTH];
    end

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        dst_d    = dst_q;
        result_d = result_q;
        rwout_d  = rwout_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    op_d    = op_e'(Op);
                    dst_d   = RW;
                    hi_d    = '0;
                    lo_d    = in_div ? a_mag : BusB;
                    opnd_d  = in_div ? b_mag : BusA;
                    neg_d   = in_sdiv && (BusA[WIDTH-1] ^ BusB[WIDTH-1]);
                    div0_d  = (BusB == '0);
                end
            end
            RUN: begin
                if ((op_q == OP_UDIV) || (op_q == OP_SDIV)) begin
                    // Restoring step: remainder never exceeds the divisor, so WIDTH bits hold it.
                    hi_d = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], rem_ge};
                end else begin
                    // Shift-add step: carry-out of the add becomes the new top product bit.
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                rwout_d = dst_q;
                case (op_q)
                    OP_MUL:  result_d = lo_q;
                    OP_UDIV,
                    OP_SDIV: result_d = div0_q ? '0 : quot_signed;
                    default: begin
`ifdef MULDIV_UMULH_EN
                        result_d = hi_q;
`else
                        result_d = '0;
`endif
                    end
                endcase
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset also aborts any operation in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            dst_q    <= '0;
            result_q <= '0;
            rwout_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            dst_q    <= dst_d;
            result_q <= result_d;
            rwout_q  <= rwout_d;
            done_q   <= done_d;
        end
    end

    assign Busy     = (state_q != IDLE);
    assign Done     = done_q;
    assign RegWrOut = done_q;
    assign Result   = result_q;
    assign RWOut    = rwout_q;

endmodule

// File: tb/tb_iterative_muldiv.sv
// Bench for iterative_muldiv: directed cases plus randomized ops against an arithmetic model.
// Expects Done exactly 65 edges after the accepting edge.
// Exercises ignored Start while busy and back-to-back Start in the Done cycle.
module tb_iterative_muldiv;
    import iterative_muldiv_pkg::*;

    localparam int W   = 64;
    localparam int RA  = 5;
    localparam int LAT = W + 1;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [1:0]    Op;
    logic [W-1:0]  BusA;
    logic [W-1:0]  BusB;
    logic [RA-1:0] RW;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  Result;
    logic [RA-1:0] RWOut;
    logic          RegWrOut;

    int n_cmp   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONE = {W{1'b1}};

    iterative_muldiv #(.WIDTH(W), .RADDR_W(RA)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Op       (Op),
        .BusA     (BusA),
        .BusB     (BusB),
        .RW       (RW),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .RWOut    (RWOut),
        .RegWrOut (RegWrOut)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Reference behaviour straight from the arithmetic definitions.
    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0]       p;
        logic signed [W-1:0]  sa;
        logic signed [W-1:0]  sb;
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        sa = a;
        sb = b;
        case (op)
            2'b00: return p[W-1:0];
            2'b01: return (b == '0) ? '0 : a / b;
            2'b10: begin
                if (b == '0) return '0;
                else if (a == MIN_NEG && sb == -1) return a;
                else return sa / sb;
            end
            default: begin
`ifdef MULDIV_UMULH_EN
                return p[2*W-1:W];
`else
                return '0;
`endif
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [RA-1:0] rw);
        Start = 1'b1;
        Op    = op;
        BusA  = a;
        BusB  = b;
        RW    = rw;
        @(posedge Clk);
        #1;
        acc_cyc = cyc;
        Start = 1'b0;
        Op    = 2'($urandom);
        BusA  = {$urandom, $urandom};
        BusB  = {$urandom, $urandom};
        RW    = RA'($urandom);
        @(negedge Clk);
        check("busy_after_accept", {63'b0, Busy}, 1);
    endtask

    // Returns at the negedge of the Done cycle.
    task automatic wait_done(input string tag, input logic [W-1:0] exp, input logic [RA-1:0] rw);
        int lat;
        while (Done !== 1'b1 && (cyc - acc_cyc) < 200) @(negedge Clk);
        lat = cyc - acc_cyc;
        check({tag, "_latency"}, W'(lat), W'(LAT));
        check({tag, "_result"}, Result, exp);
        check({tag, "_rwout"}, {59'b0, RWOut}, {59'b0, rw});
        check({tag, "_regwr"}, {63'b0, RegWrOut}, 1);
        check({tag, "_busy_in_done"}, {63'b0, Busy}, 0);
    endtask

    task automatic post_done(input string tag, input logic [W-1:0] exp);
        @(negedge Clk);
        check({tag, "_done_one_cycle"}, {62'b0, Done, RegWrOut}, 0);
        check({tag, "_result_held"}, Result, exp);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [RA-1:0] rw,
                          input logic [W-1:0] exp);
        issue(op, a, b, rw);
        wait_done(tag, exp, rw);
        post_done(tag, exp);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        int           seen;

        Reset = 1'b1;
        Start = 1'b0;
        Op    = '0;
        BusA  = '0;
        BusB  = '0;
        RW    = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy", {63'b0, Busy}, 0);
        check("rst_done", {63'b0, Done}, 0);
        check("rst_regwr", {63'b0, RegWrOut}, 0);
        check("rst_result", Result, 0);
        check("rst_rwout", {59'b0, RWOut}, 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Multiply, then confirm the result stays put while idle.
        run_op("mul", 2'b00, 64'h1234_5678, 64'h10, 5'd5, 64'h1_2345_6780);
        repeat (10) @(negedge Clk);
        check("mul_hold_result", Result, 64'h1_2345_6780);
        check("mul_hold_rwout", {59'b0, RWOut}, 64'd5);

        // Directed divides, including overflow and divide-by-zero.
        run_op("udiv", 2'b01, 64'd100, 64'd7, 5'd1, 64'd14);
        run_op("sdiv_neg", 2'b10, -64'sd100, 64'd7, 5'd2, 64'hFFFF_FFFF_FFFF_FFF2);
        run_op("sdiv_ovf", 2'b10, MIN_NEG, ALL_ONE, 5'd3, MIN_NEG);
        run_op("udiv_zero", 2'b01, 64'd5, 64'd0, 5'd4, 64'd0);
        run_op("sdiv_zero", 2'b10, -64'sd9, 64'd0, 5'd6, 64'd0);
        run_op("mul_xzr", 2'b00, 64'd3, 64'd4, 5'(XZR_IDX), 64'd12);

        // Start during RUN is dropped; Start in the Done cycle is taken.
        issue(2'b01, 64'd1000, 64'd10, 5'd3);
        repeat (10) @(negedge Clk);
        Start = 1'b1;
        Op    = 2'b00;
        BusA  = 64'd77;
        BusB  = 64'd99;
        RW    = 5'd20;
        @(negedge Clk);
        Start = 1'b0;
        wait_done("ignore_start", 64'd100, 5'd3);
        issue(2'b10, 64'd50, -64'sd5, 5'd7);
        wait_done("b2b", -64'sd10, 5'd7);
        post_done("b2b", -64'sd10);

        // Reset mid-divide aborts with no Done ever.
        issue(2'b01, 64'hDEAD_BEEF_0000_1234, 64'd3, 5'd9);
        repeat (19) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("abort_busy", {63'b0, Busy}, 0);
        check("abort_done", {63'b0, Done}, 0);
        check("abort_result", Result, 0);
        check("abort_rwout", {59'b0, RWOut}, 0);
        Reset = 1'b0;
        seen = 0;
        repeat (100) begin
            @(negedge Clk);
            if (Done !== 1'b0 || RegWrOut !== 1'b0) seen++;
        end
        check("abort_no_done", W'(seen), 0);

        // Upper-product op: all-ones squared.
`ifdef MULDIV_UMULH_EN
        run_op("umulh", 2'b11, ALL_ONE, ALL_ONE, 5'd10, 64'hFFFF_FFFF_FFFF_FFFE);
`else
        run_op("umulh", 2'b11, ALL_ONE, ALL_ONE, 5'd10, 64'd0);
`endif

        // Randomized ops checked against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = W'($urandom_range(0, 9));
                1: b = -W'($urandom_range(1, 9));
                2: a = W'($urandom);
                default: ;
            endcase
            run_op("rand", op, a, b, RA'($urandom), model(op, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iterative_muldiv.md
Name: iterative_muldiv

Overview:
- Multi-cycle execute-stage unit for MUL/UDIV/SDIV.
- Consumes the register file read buses BusA/BusB and the destination index RW.
- Produces a 64-bit write-back value plus a one-cycle write strobe aimed at the register file's BusW/RW/RegWr inputs.
- Iterates one bit per clock, so single-cycle ALU timing is not stretched by multiply/divide.

Parameters:
WIDTH, 64, operand/result width; iteration count equals WIDTH
RADDR_W, 5, register index width (32 registers; 31 = XZR)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  reset; synchronous, active-high
Start  input  1  request; sampled only in IDLE
Op  input  2  00 MUL (low WIDTH bits), 01 UDIV, 10 SDIV, 11 UMULH (see Optional Feature)
BusA  input  WIDTH  operand A / dividend
BusB  input  WIDTH  operand B / divisor
RW  input  RADDR_W  destination register, captured with Start
Busy  output  1  high from the accepting edge until Done
Done  output  1  one-cycle completion pulse
Result  output  WIDTH  final value; held until next accepted Start
RWOut  output  RADDR_W  captured destination; held with Result
RegWrOut  output  1  equals Done; write strobe for the register file

Behaviour:
- Reset: state=IDLE; Busy=0, Done=0, RegWrOut=0, Result=0, RWOut=0.
- Reset mid-operation: abort next edge, no Done/RegWrOut pulse, outputs return to reset values.
- States: IDLE -> RUN -> FIN -> IDLE.
- IDLE:
  - Start=1 at edge k captures Op, BusA, BusB, RW; Busy=1 after edge k; enter RUN; iteration counter=0.
  - Start=0: remain in IDLE; Done=0.
- RUN, one step per edge, counter 0..WIDTH-1:
  - MUL: shift-add over a 2*WIDTH product.
  - Divides: restoring divide over magnitudes; remainder WIDTH+1 bits.
  - After step WIDTH-1, go to FIN.
- FIN (edge k+WIDTH+1):
  - Apply sign correction and load Result/RWOut.
  - Done=1, RegWrOut=1, Busy=0 for exactly that one cycle.
  - Return to IDLE.
- Fixed latency: Done is high in the cycle after edge k+WIDTH+1, i.e. 65 edges after accept for WIDTH=64. Latency is identical for every Op and for every operand value.
- Start while Busy: ignored, no queuing. Start in the same cycle as Done (state IDLE on the next edge) is accepted normally, giving back-to-back operation.
- MUL: Result = (A*B) mod 2^WIDTH; identical for signed or unsigned operands.
- UDIV: Result = floor(A/B), unsigned.
- SDIV: quotient truncated toward zero; sign = signA XOR signB; operands converted to magnitude before RUN.
- Divide by zero, UDIV or SDIV: Result=0, no trap.
- SDIV overflow, A = most-negative and B = -1: Result = A (0x8000_0000_0000_0000).
- RW=31: computed and strobed normally; discard is the register file's job (XZR reads zero).
- Inputs are sampled only at the accepting edge; later changes to BusA/BusB/RW/Op do not affect the operation in flight.

Optional Feature:
- Macro MULDIV_UMULH_EN.
- Defined: Op=11 returns the upper WIDTH bits of the unsigned 2*WIDTH product, same latency.
- Undefined: Op=11 is accepted, runs the full latency and returns Result=0 with a normal Done/RegWrOut pulse. The upper-product register still exists for MUL.

Decomposition:
- Shared package:
  - Op encodings: OP_MUL, OP_UDIV, OP_SDIV, OP_UMULH.
  - State enum: IDLE/RUN/FIN.
  - XZR_IDX=31.
  - Iteration-counter width = clog2(WIDTH)+1.
- One sub-module, muldiv_signmag: combinational two's-complement abs/conditional-negate. It is used for operand magnitude on entry and for result negation in FIN.

Test Plan:
- Reset then idle: Reset=1 for 2 cycles -> Busy=0, Done=0, Result=0, RWOut=0.
- MUL: Start, Op=00, A=0x12345678, B=0x10, RW=5 -> after 65 edges, Done=RegWrOut=1 for one cycle, Result=0x123456780, RWOut=5. Result still held 10 cycles later.
- Divides:
  - UDIV 100/7 -> 14.
  - SDIV -100/7 -> -14 (0xFFFF_FFFF_FFFF_FFF2).
  - SDIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
  - UDIV 5/0 -> 0.
  - Done latency is 65 edges in all four cases.
- Start pulsed during RUN with different operands -> ignored; the first result is unchanged. A back-to-back Start during the Done cycle is accepted, and its Done arrives 65 edges later.
- Reset asserted 20 cycles into a divide -> next cycle Busy=0, no Done pulse ever occurs for that operation, Result=0.
- Op=11, A=B=0xFFFF_FFFF_FFFF_FFFF:
  - With MULDIV_UMULH_EN -> Result=0xFFFF_FFFF_FFFF_FFFE.
  - Without it -> Result=0, and Done still occurs.
